// File: rtl/pll_reconf_pkg.sv
// ============================================================================
//  Module   : pll_reconf_pkg
//  Brief    : Shared types and defaults for the PLL reconfiguration path.
//             The ROM side imports the same latency default so both ends
//             agree on read timing.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_reconf_pkg;

  localparam int unsigned DEF_CHAIN_LEN   = 144;
  localparam int unsigned DEF_ROM_LATENCY = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN   = 3'd2,
    S_UPDATE  = 3'd3,
    S_WAIT_LO = 3'd4,
    S_WAIT_HI = 3'd5,
    S_ARESET  = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pll_reconf_loader_if.sv
// ============================================================================
//  Module   : pll_reconf_loader_if
//  Brief    : Control, ROM and PLL scan-chain signals of the reconfiguration
//             loader. master = loader side, slave = environment side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pll_reconf_loader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] rom_address;
  logic       rom_read_ena;
  logic       rom_q;
  logic       scandata;
  logic       scanclkena;
  logic       configupdate;
  logic       scandone;
  logic       pll_areset;

  modport master (
    input  start, rom_q, scandone,
    output busy, done, timeout, rom_address, rom_read_ena,
           scandata, scanclkena, configupdate, pll_areset
  );

  modport slave (
    output start, rom_q, scandone,
    input  busy, done, timeout, rom_address, rom_read_ena,
           scandata, scanclkena, configupdate, pll_areset
  );
endinterface

`default_nettype wire

// File: rtl/pll_reconf_loader_latency_pipe.sv
// ============================================================================
//  Module   : latency_pipe
//  Brief    : DEPTH-stage valid shift register; out_o is in_i delayed by
//             DEPTH clocks. DEPTH must be at least 1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module latency_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_i,
  output logic out_o
);

  logic [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage delay
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pipe_q <= '0;
        else          pipe_q <= in_i;
      end
    end else begin : g_chain
      // Shift the valid bit toward the tail one stage per clock
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pipe_q <= '0;
        else          pipe_q <= {pipe_q[DEPTH-2:0], in_i};
      end
    end
  endgenerate

  assign out_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pll_reconf_loader.sv
// ============================================================================
//  Module   : pll_reconf_loader
//  Brief    : Sweeps the reconfiguration ROM, shifts one bit per address into
//             the PLL scan chain (address 0 first), pulses configupdate,
//             waits for the scandone handshake and optionally resets the PLL.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reconf_loader
  import pll_reconf_pkg::*;
#(
  parameter int unsigned CHAIN_LEN     = DEF_CHAIN_LEN,
  parameter int unsigned ROM_LATENCY   = DEF_ROM_LATENCY,
  parameter int unsigned ARESET_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic                clock,
  input  logic                reset_n,
  pll_reconf_loader_if.master bus
);

  localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned       ARS_W     = (ARESET_CYCLES > 1) ? $clog2(ARESET_CYCLES) : 1;
  localparam logic [7:0]        LAST_ADDR = 8'(CHAIN_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
  localparam logic [ARS_W-1:0]  ARS_LAST  = ARS_W'((ARESET_CYCLES > 0) ? ARESET_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [ARS_W-1:0]   ars_q, ars_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               rd_ena_q, rd_ena_d;
  logic               cfg_q, cfg_d;
  logic               areset_q, areset_d;
  logic               scandata_q, sce_q;
  logic               tail;

  // Matches the ROM read latency: tail marks the cycle rom_q is valid
  latency_pipe #(.DEPTH(ROM_LATENCY)) u_valid_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_i    (rd_ena_q),
    .out_o   (tail)
  );

  // Saturating increment of the handshake wait counter
  assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

  // Next-state and next-output decode; outputs follow the next state so
  // every port is driven straight from a flop
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tmo_d     = tmo_q;
    ars_d     = ars_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done/timeout high means IDLE was just entered: start is dropped
        if (bus.start && !done_q && !timeout_q) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                     addr_d  = addr_q + 8'd1;
      end
      S_DRAIN: begin
        // Last bit is on the chain and nothing more is in flight
        if (sce_q && !tail) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_WAIT_LO;
        tmo_d   = '0;
      end
      S_WAIT_LO: begin
        tmo_d = tmo_inc;
        if (!bus.scandone) begin
          state_d = S_WAIT_HI;
        end else if (tmo_inc == TMO_MAX) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_WAIT_HI: begin
        tmo_d = tmo_inc;
        if (bus.scandone) begin
          if (ARESET_CYCLES == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ARESET;
            ars_d   = '0;
          end
        end else if (tmo_inc == TMO_MAX) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_ARESET: begin
        if (ars_q == ARS_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ars_d = ars_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    rd_ena_d = (state_d == S_READ);
    cfg_d    = (state_d == S_UPDATE);
    areset_d = (state_d == S_ARESET);
  end

  // State, counters and registered control outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      tmo_q     <= '0;
      ars_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_ena_q  <= 1'b0;
      cfg_q     <= 1'b0;
      areset_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      ars_q     <= ars_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rd_ena_q  <= rd_ena_d;
      cfg_q     <= cfg_d;
      areset_q  <= areset_d;
    end
  end

  // Capture each valid ROM bit and present it to the scan chain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scandata_q <= 1'b0;
      sce_q      <= 1'b0;
    end else begin
      sce_q <= tail;
      if (tail) scandata_q <= bus.rom_q;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.rom_address  = addr_q;
  assign bus.rom_read_ena = rd_ena_q;
  assign bus.scandata     = scandata_q;
  assign bus.scanclkena   = sce_q;
  assign bus.configupdate = cfg_q;
  assign bus.pll_areset   = areset_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconf_loader.sv
// ============================================================================
//  Module   : tb_pll_reconf_loader
//  Brief    : Self-checking bench for pll_reconf_loader: default instance
//             (144 bits, latency 2, 4-cycle areset) and a small instance
//             (8 bits, latency 3, no areset).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pll_reconf_loader;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pll_reconf_loader_if bus0();
  pll_reconf_loader_if bus1();

  pll_reconf_loader #(.CHAIN_LEN(144), .ROM_LATENCY(2), .ARESET_CYCLES(4), .TIMEOUT(1023)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0));
  pll_reconf_loader #(.CHAIN_LEN(8), .ROM_LATENCY(3), .ARESET_CYCLES(0), .TIMEOUT(1023)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1));

  // ROM content: bit = address[0] ^ address[3]
  function automatic logic patt(input logic [7:0] a);
    return a[0] ^ a[3];
  endfunction

  // ROM models: 2-cycle and 3-cycle read latency
  logic [1:0] rom0_q = '0;
  logic [2:0] rom1_q = '0;
  always @(posedge clock) begin
    rom0_q <= {rom0_q[0], patt(bus0.rom_address)};
    rom1_q <= {rom1_q[1:0], patt(bus1.rom_address)};
  end
  assign bus0.rom_q = rom0_q[1];
  assign bus1.rom_q = rom1_q[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic       busy;
    logic       rd;
    logic [7:0] addr;
    logic       sce;
    logic       cfg;
    logic       ars;
    logic       done;
  } vec_t;

  vec_t tbl [15];

  // Observations of one run of dut0
  int n_shift, first_shift, last_shift, shift_err;
  int n_cfg, cfg_at, n_ars, n_done, done_at, n_tmo, tmo_at, busy_fall;

  task automatic run0(input int ncyc, input int pll_mode, input int start2,
                      input int start3, input int rst_at, input bit use_tbl);
    n_shift = 0; first_shift = -1; last_shift = -1; shift_err = 0;
    n_cfg = 0; cfg_at = -1; n_ars = 0; n_done = 0; done_at = -1;
    n_tmo = 0; tmo_at = -1; busy_fall = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (use_tbl) begin
        for (int r = 0; r < 15; r++) begin
          if (tbl[r].cyc == c) begin
            chk($sformatf("c%0d busy", c), 32'(bus0.busy), 32'(tbl[r].busy));
            chk($sformatf("c%0d rom_read_ena", c), 32'(bus0.rom_read_ena), 32'(tbl[r].rd));
            if (tbl[r].rd)
              chk($sformatf("c%0d rom_address", c), 32'(bus0.rom_address), 32'(tbl[r].addr));
            chk($sformatf("c%0d scanclkena", c), 32'(bus0.scanclkena), 32'(tbl[r].sce));
            chk($sformatf("c%0d configupdate", c), 32'(bus0.configupdate), 32'(tbl[r].cfg));
            chk($sformatf("c%0d pll_areset", c), 32'(bus0.pll_areset), 32'(tbl[r].ars));
            chk($sformatf("c%0d done", c), 32'(bus0.done), 32'(tbl[r].done));
          end
        end
      end
      if (bus0.scanclkena === 1'b1) begin
        if (first_shift < 0) first_shift = c;
        last_shift = c;
        if (bus0.scandata !== patt(8'(n_shift))) shift_err++;
        n_shift++;
      end
      if (bus0.configupdate === 1'b1) begin
        n_cfg++;
        if (cfg_at < 0) cfg_at = c;
      end
      if (bus0.pll_areset === 1'b1) n_ars++;
      if (bus0.done === 1'b1) begin n_done++; done_at = c; end
      if (bus0.timeout === 1'b1) begin n_tmo++; tmo_at = c; end
      if (c > 0 && bus0.busy !== 1'b1 && busy_fall < 0) busy_fall = c;

      bus0.start = (c == 0 || c == start2 || c == start3);
      if (pll_mode == 1 && cfg_at >= 0) begin
        if (c == cfg_at + 3)  bus0.scandone = 1'b0;
        if (c == cfg_at + 23) bus0.scandone = 1'b1;
      end
      if (rst_at >= 0 && c == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({bus0.busy, bus0.done, bus0.timeout, bus0.rom_address,
            bus0.rom_read_ena, bus0.scandata, bus0.scanclkena, bus0.configupdate,
            bus0.pll_areset}), 32'd0);
      end
      if (rst_at >= 0 && c == rst_at + 2) reset_n = 1'b1;
      @(negedge clock);
    end
    bus0.start    = 1'b0;
    bus0.scandone = 1'b1;
  endtask

  // Observations of one run of dut1
  int s_shift, s_first, s_err, s_cfg, s_ncfg, s_done, s_ndone, s_ars;

  task automatic run1(input int ncyc);
    s_shift = 0; s_first = -1; s_err = 0; s_cfg = -1; s_ncfg = 0;
    s_done = -1; s_ndone = 0; s_ars = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (bus1.scanclkena === 1'b1) begin
        if (s_first < 0) s_first = c;
        if (bus1.scandata !== patt(8'(s_shift))) s_err++;
        s_shift++;
      end
      if (bus1.configupdate === 1'b1) begin s_ncfg++; s_cfg = c; end
      if (bus1.done === 1'b1) begin s_ndone++; s_done = c; end
      if (bus1.pll_areset === 1'b1) s_ars++;
      bus1.start = (c == 0);
      if (s_cfg >= 0 && c == s_cfg + 3) bus1.scandone = 1'b0;
      if (s_cfg >= 0 && c == s_cfg + 7) bus1.scandone = 1'b1;
      @(negedge clock);
    end
    bus1.start    = 1'b0;
    bus1.scandone = 1'b1;
  endtask

  initial begin
    bus0.start = 1'b0; bus0.scandone = 1'b1;
    bus1.start = 1'b0; bus1.scandone = 1'b1;

    //            cyc busy rd  addr   sce cfg ars done
    tbl[0]  = '{  0,  0,  0, 8'd0,    0,  0,  0,  0};
    tbl[1]  = '{  1,  1,  1, 8'd0,    0,  0,  0,  0};
    tbl[2]  = '{  2,  1,  1, 8'd1,    0,  0,  0,  0};
    tbl[3]  = '{  3,  1,  1, 8'd2,    0,  0,  0,  0};
    tbl[4]  = '{  4,  1,  1, 8'd3,    1,  0,  0,  0};
    tbl[5]  = '{144,  1,  1, 8'd143,  1,  0,  0,  0};
    tbl[6]  = '{145,  1,  0, 8'd0,    1,  0,  0,  0};
    tbl[7]  = '{147,  1,  0, 8'd0,    1,  0,  0,  0};
    tbl[8]  = '{148,  1,  0, 8'd0,    0,  1,  0,  0};
    tbl[9]  = '{149,  1,  0, 8'd0,    0,  0,  0,  0};
    tbl[10] = '{171,  1,  0, 8'd0,    0,  0,  0,  0};
    tbl[11] = '{172,  1,  0, 8'd0,    0,  0,  1,  0};
    tbl[12] = '{175,  1,  0, 8'd0,    0,  0,  1,  0};
    tbl[13] = '{176,  0,  0, 8'd0,    0,  0,  0,  1};
    tbl[14] = '{177,  0,  0, 8'd0,    0,  0,  0,  0};

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset outputs", 32'({bus0.busy, bus0.done, bus0.timeout, bus0.rom_address,
        bus0.rom_read_ena, bus0.scandata, bus0.scanclkena, bus0.configupdate,
        bus0.pll_areset}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Full sweep + handshake, extra starts during READ and coincident with done
    run0(400, 1, 50, 176, -1, 1'b1);
    chk("sweep shift count", n_shift, 144);
    chk("sweep first shift", first_shift, 4);
    chk("sweep last shift", last_shift, 147);
    chk("sweep bit errors", shift_err, 0);
    chk("sweep configupdate count", n_cfg, 1);
    chk("sweep configupdate cycle", cfg_at, 148);
    chk("sweep areset cycles", n_ars, 4);
    chk("sweep done count", n_done, 1);
    chk("sweep done cycle", done_at, 176);
    chk("sweep timeout count", n_tmo, 0);
    chk("sweep busy fall", busy_fall, 176);

    // scandone stuck high: wait states last TIMEOUT cycles then timeout
    run0(1300, 0, -1, -1, -1, 1'b0);
    chk("stuck timeout count", n_tmo, 1);
    chk("stuck timeout cycle", tmo_at, 148 + 1 + 1023);
    chk("stuck done count", n_done, 0);
    chk("stuck areset cycles", n_ars, 0);
    chk("stuck busy fall", busy_fall, 1172);

    // Reset at cycle 60 abandons the chain
    run0(200, 1, -1, -1, 60, 1'b0);
    chk("reset shifts before abort", n_shift, 57);
    chk("reset bit errors", shift_err, 0);
    chk("reset configupdate count", n_cfg, 0);
    chk("reset done count", n_done, 0);
    chk("reset busy fall", busy_fall, 61);

    // Fresh sweep after reset release
    run0(400, 1, -1, -1, -1, 1'b0);
    chk("resweep shift count", n_shift, 144);
    chk("resweep bit errors", shift_err, 0);
    chk("resweep configupdate cycle", cfg_at, 148);
    chk("resweep done cycle", done_at, 176);

    // Small instance: 8 bits, latency 3, no areset
    run1(40);
    chk("small first shift", s_first, 5);
    chk("small shift count", s_shift, 8);
    chk("small bit errors", s_err, 0);
    chk("small configupdate cycle", s_cfg, 13);
    chk("small configupdate count", s_ncfg, 1);
    chk("small done cycle", s_done, 21);
    chk("small done count", s_ndone, 1);
    chk("small areset cycles", s_ars, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_reconf_loader.md
# pll_reconf_loader

Initiator side of the HDMI PLL reconfiguration path. On a start pulse it sweeps the reconfiguration ROM address space, reads one scan-chain bit per address with fixed read latency, and shifts the bits into the PLL scan chain. It then pulses `configupdate`, waits for the PLL's `scandone` handshake, and optionally pulses the PLL reset. It sits between the mode-change control logic and the `altpll` reconfiguration ports, and replaces the vendor reconfig megafunction's ROM-read/shift engine.

## Interface
Parameters:
- `CHAIN_LEN`, 144: scan-chain length in bits; number of ROM addresses read (0 .. CHAIN_LEN-1).
- `ROM_LATENCY`, 2: cycles from `rom_read_ena`/`rom_address` to valid `rom_q`.
- `ARESET_CYCLES`, 4: width of the `pll_areset` pulse after a successful update; 0 disables it.
- `TIMEOUT`, 1023: maximum cycles spent in the `scandone` wait.

Ports:
- `clock`  in  1: single clock, also used as the PLL `scanclk`.
- `reset_n`  in  1: one clock; reset is asynchronous and active-low.
- `start`  in  1: request reconfiguration; sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on successful completion.
- `timeout`  out  1: one-cycle pulse when `scandone` does not complete.
- `rom_address`  out  8: ROM bit address.
- `rom_read_ena`  out  1: ROM read strobe.
- `rom_q`  in  1: ROM data, valid ROM_LATENCY cycles after the strobe.
- `scandata`  out  1: serial data to the PLL.
- `scanclkena`  out  1: shift enable to the PLL.
- `configupdate`  out  1: one-cycle update pulse.
- `scandone`  in  1: PLL scan/update complete.
- `pll_areset`  out  1: PLL reset pulse.

## Operation
- Reset: all outputs are 0, state is IDLE, and all counters are 0.
- States:
  - IDLE: wait for `start`.
  - READ: issue one address per cycle.
  - DRAIN: wait for the remaining latency.
  - UPDATE: pulse `configupdate`.
  - WAIT_LO: wait for `scandone` to go low.
  - WAIT_HI: wait for `scandone` to go high.
  - ARESET: hold `pll_areset`.
- IDLE → READ on `start`=1. The address counter is cleared to 0.
- READ:
  - `rom_read_ena`=1 and `rom_address`=counter.
  - The counter increments every cycle.
  - After the cycle that issues address CHAIN_LEN-1, go to DRAIN.
  - `rom_read_ena` drops to 0 on leaving READ.
- Valid pipeline: a `ROM_LATENCY`-deep shift register of `rom_read_ena`. When its tail is 1, `rom_q` is registered into `scandata` and `scanclkena` is set to 1 in the next cycle; otherwise `scanclkena`=0.
- Bit order: address 0 is shifted first.
- `scanclkena` is high for exactly CHAIN_LEN consecutive cycles.
- DRAIN → UPDATE in the cycle after the final `scanclkena`=1 cycle.
- UPDATE lasts one cycle with `configupdate`=1, then goes to WAIT_LO. The timeout counter is cleared.
- WAIT_LO → WAIT_HI when `scandone`=0.
- WAIT_HI → ARESET when `scandone`=1. If ARESET_CYCLES=0, go directly to IDLE with `done`.
- ARESET: `pll_areset`=1 for ARESET_CYCLES cycles, then IDLE with `done`=1 for one cycle.
- Timeout:
  - The counter runs in WAIT_LO and WAIT_HI.
  - When it reaches TIMEOUT, go to IDLE, pulse `timeout`, and do not assert `pll_areset`.
- `start` outside IDLE is ignored and not queued. This includes `start` coincident with `done`/`timeout`, which are registered in the cycle IDLE is entered.
- `reset_n` low mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - A partially shifted chain is abandoned; `configupdate` is never issued.
- Widths:
  - Address counter is 8 bits; CHAIN_LEN ≤ 256 is required.
  - Timeout counter is `$clog2(TIMEOUT+1)` bits and saturating.

## Timing
- Let `start` be sampled in cycle 0:
  - Addresses 0..CHAIN_LEN-1 are issued in cycles 1..CHAIN_LEN.
  - Bit k is on `scandata` with `scanclkena`=1 in cycle k+2+ROM_LATENCY.
  - `configupdate` is in cycle CHAIN_LEN+2+ROM_LATENCY.
- With defaults, the first shift is in cycle 4, the last shift in cycle 147, and `configupdate` in cycle 148.
- Total latency to `done` = 148 + PLL handshake + ARESET_CYCLES + 1.
- `busy` rises in cycle 1 and falls together with the `done`/`timeout` pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- A shared package `pll_reconf_pkg` holds:
  - the state enum,
  - default CHAIN_LEN/ROM_LATENCY constants, shared with the ROM side so both ends agree on latency.
- One sub-module is natural: `latency_pipe`, the parameterised valid shift register, which is reused by the ROM-side delay matching.

## Test plan
- ROM model with 2-cycle latency holding pattern `bit = address[0] ^ address[3]`; pulse `start` → exactly 144 `scanclkena` cycles, captured stream equals the pattern address 0 first, `configupdate` in cycle 148.
- PLL model drops `scandone` 3 cycles after `configupdate` and raises it 20 cycles later → `pll_areset` high for 4 cycles, then a `done` pulse; `busy` low after it.
- `scandone` held at 1 → `timeout` pulse 1023 cycles after UPDATE, no `pll_areset`, no `done`.
- `start` pulses during READ and coincident with `done` → ignored; exactly one sweep and no second `configupdate`.
- `reset_n` asserted at cycle 60 → all outputs 0 immediately; new `start` after release performs a complete 144-bit sweep.
- CHAIN_LEN=8, ROM_LATENCY=3, ARESET_CYCLES=0 → first shift in cycle 5, 8 shifts, `done` directly after `scandone` rises.
